// File: rtl/read_ctrl.sv
// read_ctrl: drains the two-slot ping-pong buffer filled by write_ctrl in strict
// round-robin order, presents each word on a valid/ready port, then releases the slot.
module read_ctrl #(
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [1:0]    status_vld,
  input  logic [DW-1:0] r_data,
  input  logic          dout_rdy,
  output logic          r_addr,
  output logic          r_en,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic [1:0]    r_done,
  output logic          empty
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    REL  = 3'd4
  } state_t;

  // RD_LAT is limited to 1..3, so the remaining wait always fits in two bits.
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t        state, state_nxt;
  logic [1:0]    cnt, cnt_nxt;
  logic          r_addr_nxt;
  logic [DW-1:0] dout_nxt;
  logic          dout_vld_nxt;
  logic [1:0]    r_done_nxt;
  logic          slot_full;

  assign slot_full = status_vld[r_addr];
  assign empty     = (status_vld == 2'b00);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt    = state;
    cnt_nxt      = cnt;
    r_addr_nxt   = r_addr;
    dout_nxt     = dout;
    dout_vld_nxt = dout_vld;
    r_done_nxt   = r_done;
    r_en         = 1'b0;

    case (state)
      IDLE: begin
        // Only the slot under the pointer is considered; the other waits its turn.
        if (slot_full) state_nxt = RD;
      end
      RD: begin
        r_en      = 1'b1;
        cnt_nxt   = LAT_LOAD;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          dout_nxt     = r_data;
          dout_vld_nxt = 1'b1;
          state_nxt    = OUT;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      OUT: begin
        if (dout_rdy) begin
          dout_vld_nxt = 1'b0;
          r_done_nxt   = r_addr ? 2'b10 : 2'b01;
          state_nxt    = REL;
        end
      end
      REL: begin
        // write_ctrl only looks at r_done while idle, so the request is held
        // until the slot flag is actually seen low.
        if (!slot_full) begin
          r_done_nxt = 2'b00;
          r_addr_nxt = ~r_addr;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        cnt_nxt      = 2'd0;
        dout_vld_nxt = 1'b0;
        r_done_nxt   = 2'b00;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      r_addr   <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      r_done   <= 2'b00;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      r_addr   <= r_addr_nxt;
      dout     <= dout_nxt;
      dout_vld <= dout_vld_nxt;
      r_done   <= r_done_nxt;
    end
  end

endmodule

// File: tb/tb_read_ctrl.sv
// tb_read_ctrl: runs RD_LAT=1 and RD_LAT=3 instances side by side against a
// write_ctrl/RAM environment and a timestamp-based transaction reference model.
module tb_read_ctrl;

  localparam int DW = 8;
  localparam int N  = 2;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic [N-1:0][1:0]    status_vld;
  logic [N-1:0][DW-1:0] r_data;
  logic [N-1:0]         dout_rdy;
  logic [N-1:0]         r_addr, r_en, dout_vld, empty;
  logic [N-1:0][DW-1:0] dout;
  logic [N-1:0][1:0]    r_done;

  read_ctrl #(.DW(DW), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .n_rst(n_rst), .status_vld(status_vld[0]), .r_data(r_data[0]),
    .dout_rdy(dout_rdy[0]), .r_addr(r_addr[0]), .r_en(r_en[0]), .dout(dout[0]),
    .dout_vld(dout_vld[0]), .r_done(r_done[0]), .empty(empty[0])
  );

  read_ctrl #(.DW(DW), .RD_LAT(3)) u_dut_lat3 (
    .clk(clk), .n_rst(n_rst), .status_vld(status_vld[1]), .r_data(r_data[1]),
    .dout_rdy(dout_rdy[1]), .r_addr(r_addr[1]), .r_en(r_en[1]), .dout(dout[1]),
    .dout_vld(dout_vld[1]), .r_done(r_done[1]), .empty(empty[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // environment knobs
  int fill_prob, rdy_prob, rel_min, rel_max, early_prob;
  logic [DW-1:0] dir_word [4];
  int dir_n;

  // environment state (write_ctrl + RAM), per instance
  logic [DW-1:0] ram [N][2];
  bit            fill_ptr [N];
  int            fill_credit [N];
  int            fill_total [N];
  int            dir_idx [N];
  int            rel_wait [N];
  bit [3:0]      ren_hist [N];
  bit [3:0]      addr_hist [N];
  logic [1:0]    prev_r_done [N];
  bit            prev_vld [N], prev_rdy [N], prev_addr [N];

  // reference model: one transaction at a time, described by timestamps
  bit            m_busy [N], m_rel [N], m_ptr [N];
  int            m_ts [N];
  logic [DW-1:0] m_word [N];

  // observations of the DUT used by directed checks
  int            fill_cyc [N], vld_rise [N], hs_cnt [N];
  logic [DW-1:0] hs_last [N], hs_prev [N];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_all();
    for (int k = 0; k < N; k++) begin
      status_vld[k]  = 2'b00;
      dout_rdy[k]    = 1'b0;
      r_data[k]      = '0;
      fill_ptr[k]    = 1'b0;
      fill_credit[k] = 0;
      dir_idx[k]     = 0;
      rel_wait[k]    = 0;
      ren_hist[k]    = '0;
      addr_hist[k]   = '0;
      prev_r_done[k] = 2'b00;
      prev_vld[k]    = 1'b0;
      prev_rdy[k]    = 1'b0;
      prev_addr[k]   = 1'b0;
      m_busy[k]      = 1'b0;
      m_rel[k]       = 1'b0;
      m_ptr[k]       = 1'b0;
      m_ts[k]        = 0;
      m_word[k]      = '0;
    end
  endtask

  task automatic drive_env(input int k);
    int            slot;
    bit            skip_fill;
    logic [DW-1:0] word;
    int            lat;
    lat       = lat_of(k);
    skip_fill = 1'b0;
    if (!n_rst) begin
      status_vld[k] = 2'b00;
      dout_rdy[k]   = 1'b0;
      r_data[k]     = DW'($urandom);
      return;
    end
    // write_ctrl answers a release request after a programmable delay
    if (prev_r_done[k] != 2'b00) begin
      slot = prev_r_done[k][1] ? 1 : 0;
      if (status_vld[k][slot]) begin
        if (rel_wait[k] == 0) status_vld[k][slot] = 1'b0;
        else rel_wait[k]--;
      end
    end else begin
      rel_wait[k] = int'($urandom_range(rel_max, rel_min));
    end
    // occasional external clear landing in the first release cycle
    if (prev_vld[k] && prev_rdy[k] && int'($urandom_range(99, 0)) < early_prob) begin
      status_vld[k][prev_addr[k]] = 1'b0;
      skip_fill = 1'b1;
    end
    // fills strictly alternate 0,1,0,1 and never target a slot still being released
    if (!skip_fill && fill_credit[k] > 0 && !status_vld[k][fill_ptr[k]] &&
        !prev_r_done[k][fill_ptr[k]] && int'($urandom_range(99, 0)) < fill_prob) begin
      if (dir_idx[k] < dir_n) begin
        word = dir_word[dir_idx[k]];
        dir_idx[k]++;
      end else begin
        word = DW'($urandom);
      end
      ram[k][fill_ptr[k]]         = word;
      status_vld[k][fill_ptr[k]]  = 1'b1;
      fill_cyc[k]                 = cyc;
      fill_ptr[k]                 = ~fill_ptr[k];
      fill_credit[k]--;
      fill_total[k]++;
    end
    dout_rdy[k] = (int'($urandom_range(99, 0)) < rdy_prob);
    // RAM: data is valid only RD_LAT cycles after r_en, garbage otherwise
    r_data[k] = ren_hist[k][lat-1] ? ram[k][addr_hist[k][lat-1]] : DW'($urandom);
  endtask

  task automatic sample_check(input int k);
    bit         exp_en, exp_vld;
    logic [1:0] exp_done;
    string      p;
    int         lat;
    lat = lat_of(k);
    p   = (k == 0) ? "lat1" : "lat3";
    if (n_rst) begin
      exp_en   = m_busy[k] && !m_rel[k] && (cyc == m_ts[k] + 1);
      exp_vld  = m_busy[k] && !m_rel[k] && (cyc >= m_ts[k] + 2 + lat);
      exp_done = m_rel[k] ? (m_ptr[k] ? 2'b10 : 2'b01) : 2'b00;
      check({p, " r_en"},     32'(r_en[k]),     32'(exp_en));
      check({p, " dout_vld"}, 32'(dout_vld[k]), 32'(exp_vld));
      check({p, " r_done"},   32'(r_done[k]),   32'(exp_done));
      check({p, " r_addr"},   32'(r_addr[k]),   32'(m_ptr[k]));
      check({p, " empty"},    32'(empty[k]),    32'(status_vld[k] == 2'b00));
      if (exp_vld) check({p, " dout"}, 32'(dout[k]), 32'(m_word[k]));
      if (dout_vld[k] && !prev_vld[k]) vld_rise[k] = cyc;
      if (dout_vld[k] && dout_rdy[k]) begin
        hs_cnt[k]++;
        hs_prev[k] = hs_last[k];
        hs_last[k] = dout[k];
      end
      if (!m_busy[k]) begin
        if (status_vld[k][m_ptr[k]]) begin
          m_busy[k] = 1'b1;
          m_ts[k]   = cyc;
          m_word[k] = ram[k][m_ptr[k]];
        end
      end else if (m_rel[k]) begin
        if (!status_vld[k][m_ptr[k]]) begin
          m_busy[k] = 1'b0;
          m_rel[k]  = 1'b0;
          m_ptr[k]  = ~m_ptr[k];
        end
      end else if (exp_vld && dout_rdy[k]) begin
        m_rel[k] = 1'b1;
      end
    end
    prev_r_done[k] = r_done[k];
    prev_vld[k]    = dout_vld[k];
    prev_rdy[k]    = dout_rdy[k];
    prev_addr[k]   = r_addr[k];
    ren_hist[k]    = {ren_hist[k][2:0], r_en[k]};
    addr_hist[k]   = {addr_hist[k][2:0], r_addr[k]};
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < N; k++) drive_env(k);
    @(negedge clk);
    for (int k = 0; k < N; k++) sample_check(k);
  endtask

  task automatic arm(input int credit, input int fprob, input int rprob);
    for (int k = 0; k < N; k++) begin
      fill_credit[k] = credit;
      dir_idx[k]     = 0;
    end
    fill_prob = fprob;
    rdy_prob  = rprob;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = 1'b1;
      for (int k = 0; k < N; k++)
        if (m_busy[k] || status_vld[k] != 2'b00 || fill_credit[k] != 0) done = 1'b0;
    end
    check({tag, " settle"}, 32'(done), 32'd1);
  endtask

  task automatic wait_vld(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = dout_vld[0] && dout_vld[1];
    end
    check({tag, " reach out"}, 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < N; k++) begin
      check({tag, " dout_vld"}, 32'(dout_vld[k]), 32'd0);
      check({tag, " r_en"},     32'(r_en[k]),     32'd0);
      check({tag, " r_done"},   32'(r_done[k]),   32'd0);
      check({tag, " r_addr"},   32'(r_addr[k]),   32'd0);
      check({tag, " dout"},     32'(dout[k]),     32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst      = 1'b0;
    fill_prob  = 0;
    rdy_prob   = 0;
    rel_min    = 0;
    rel_max    = 0;
    early_prob = 0;
    dir_n      = 0;
    for (int k = 0; k < N; k++) begin
      fill_total[k] = 0;
      hs_cnt[k]     = 0;
      hs_last[k]    = '0;
      hs_prev[k]    = '0;
      fill_cyc[k]   = 0;
      vld_rise[k]   = 0;
    end
    reset_all();
    repeat (3) step();
    check_reset_outputs("reset");
    #2 n_rst = 1'b1;
    repeat (4) step();

    // single word, ready held high
    dir_word[0] = 8'hA5;
    dir_n       = 1;
    arm(1, 100, 100);
    wait_idle("single", 40);
    for (int k = 0; k < N; k++) begin
      check("single fill->vld latency", 32'(vld_rise[k] - fill_cyc[k]), 32'(2 + lat_of(k)));
      check("single handshakes", 32'(hs_cnt[k]), 32'd1);
    end

    // backpressure: ready low for 5 cycles while the word is presented
    arm(1, 100, 0);
    wait_vld("bp", 20);
    repeat (5) begin
      step();
      for (int k = 0; k < N; k++) begin
        check("bp dout held", 32'(dout[k]), 32'h0A5);
        check("bp vld held", 32'(dout_vld[k]), 32'd1);
      end
    end
    rdy_prob = 100;
    wait_idle("bp", 40);

    // release acknowledged three cycles late
    dir_n   = 0;
    rel_min = 3;
    rel_max = 3;
    arm(1, 100, 100);
    wait_idle("held release", 50);
    rel_min = 0;
    rel_max = 0;

    // both slots full: words must come out in fill order
    dir_word[0] = 8'h11;
    dir_word[1] = 8'h22;
    dir_n       = 2;
    arm(2, 100, 100);
    wait_idle("both full", 60);
    for (int k = 0; k < N; k++) begin
      check("both full first word", 32'(hs_prev[k]), 32'h11);
      check("both full second word", 32'(hs_last[k]), 32'h22);
      check("directed handshakes", 32'(hs_cnt[k]), 32'd5);
    end

    // randomized traffic
    dir_n      = 0;
    rel_max    = 3;
    early_prob = 10;
    arm(100000, 40, 60);
    repeat (1500) step();
    for (int k = 0; k < N; k++) fill_credit[k] = 0;
    rdy_prob   = 100;
    early_prob = 0;
    wait_idle("random", 200);
    for (int k = 0; k < N; k++)
      check("random words consumed", 32'(hs_cnt[k]), 32'(fill_total[k]));
    rel_max = 0;

    // asynchronous reset while a word is being presented
    arm(1, 100, 0);
    wait_vld("mid reset", 30);
    #2 n_rst = 1'b0;
    #1;
    check_reset_outputs("async reset");
    reset_all();
    repeat (2) step();
    #2 n_rst = 1'b1;
    repeat (5) step();
    for (int k = 0; k < N; k++) begin
      check("post reset empty", 32'(empty[k]), 32'd1);
      check("post reset no read", 32'(r_en[k]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/read_ctrl.md
Name: read_ctrl

Overview:
Downstream consumer of the two-slot ping-pong buffer filled by write_ctrl. It watches the per-slot valid flags (status_vld), reads each filled slot from the 2x8 buffer RAM in round-robin order, and presents the word on a valid/ready output port. It releases each slot back to write_ctrl by asserting r_done, and holds that request until the slot flag is observed cleared. write_ctrl only samples r_done while idle, so a one-cycle pulse is not sufficient.

Parameters:
DW, 8, data width of RAM word and dout; must equal write_ctrl w_data width.
RD_LAT, 1, RAM read latency in cycles from r_en to valid r_data; legal range 1..3.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous, active-low reset.
status_vld  input  2  slot-full flags from write_ctrl; bit i = slot i holds unread data.
r_data  input  DW  RAM read data, valid RD_LAT cycles after r_en.
dout_rdy  input  1  downstream ready.
r_addr  output  1  RAM read address / current slot pointer.
r_en  output  1  RAM read enable, one-cycle pulse per slot.
dout  output  DW  registered output word.
dout_vld  output  1  dout valid.
r_done  output  2  slot-release request to write_ctrl; one-hot, registered.
empty  output  1  combinational, 1 when status_vld == 2'b00.

Behaviour:
- Reset (async, n_rst=0): state=IDLE, r_addr=0, r_en=0, dout=0, dout_vld=0, r_done=2'b00, latency counter=0. Reset mid-operation aborts any read or release. No partial word is presented after reset. write_ctrl shares n_rst, so the slot flags clear together.
- FSM states:
  - IDLE: if status_vld[r_addr]=1, go to RD. Otherwise stay. The other slot is never read out of order, even if it is full.
  - RD: r_en=1 for exactly this cycle. Load the counter with RD_LAT-1 and go to WAIT.
  - WAIT: if the counter is 0, capture r_data into dout at the clock edge, set dout_vld=1, and go to OUT. Otherwise decrement the counter.
  - OUT: dout_vld=1. dout holds stable while dout_rdy=0. When dout_rdy=1, the transfer completes at the edge: dout_vld<=0, r_done[r_addr]<=1, go to REL.
  - REL: hold r_done[r_addr]=1. When status_vld[r_addr]=0 is sampled, clear r_done to 2'b00 at the edge, toggle r_addr, and go to IDLE.
- Latency: with RD_LAT=1 and dout_rdy held high, status_vld[r_addr] rises in cycle 0; r_en is high in cycle 1; dout_vld is high in cycle 3.
- Throughput: at most one word per slot fill. Minimum loop per slot = 4 + RD_LAT cycles plus the write_ctrl release latency.
- r_done is never 2'b11, and is never asserted for a slot whose status bit is 0 at assertion time.
- Simultaneous events:
  - write_ctrl refilling the other slot during REL has no effect until r_addr advances.
  - If status_vld[r_addr] is already 0 in the first REL cycle (external clear), r_done still asserts for one cycle, then REL exits.
- Ordering: slots are consumed 0,1,0,1,..., matching write_ctrl's fill order.
- empty is purely combinational from status_vld and is independent of FSM state.
- Unused FSM encodings return to IDLE with all outputs deasserted.

Test Plan:
1. Reset values: drive n_rst=0 mid-OUT with dout_vld=1 -> dout_vld, r_en, r_done=2'b00 and r_addr=0 immediately (async). After release, IDLE with status_vld=00 -> no r_en, empty=1.
2. Single word, RD_LAT=1, dout_rdy=1: set status_vld=01 with RAM[0]=8'hA5 -> r_en pulse at cycle 1 with r_addr=0; dout=8'hA5, dout_vld=1 at cycle 3; r_done=01 from cycle 4 until status_vld[0]=0, then r_done=00 and r_addr=1.
3. Backpressure: dout_rdy=0 for 5 cycles during OUT -> dout_vld=1 and dout=8'hA5 stable all 5 cycles. r_done stays 00 until the cycle after dout_rdy rises.
4. Held release: model write_ctrl clearing status_vld[0] 3 cycles late -> r_done=01 held for all those cycles, exactly one clear, no second read of slot 0.
5. Ordering with both slots full: status_vld=11, RAM={8'h11,8'h22} -> outputs 8'h11 then 8'h22. r_done sequence 01 then 10, never 11. empty=0 until both cleared.
6. RD_LAT=3 build: single slot -> dout_vld rises exactly 5 cycles after status_vld[0] rises, and the captured word equals r_data in the cycle RD_LAT after r_en.
